seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, each one nibble of value.
REQ-002 Parameter DIV, default 50000: clock cycles per digit slot; legal range DIV >= DEAD+2.
REQ-003 Parameter DEAD, default 16: cycles at slot start with all anodes off (anti-ghosting).
REQ-004 clk  in  1: single clock; all state updates on rising edge.
REQ-005 rst  in  1: reset, synchronous, active-high.
REQ-006 value  in  4*NUM_DIGITS: hex value to display; nibble 0 (LSBs) is the rightmost digit.
REQ-007 load  in  1: one-cycle strobe; captures value into the pending register.
REQ-008 enable  in  1: scanning enable.
REQ-009 lz_blank  in  1: leading-zero blanking enable.
REQ-010 digit  out  4: nibble currently selected; drives the decoder input.
REQ-011 seg  out  7: decoder output for digit.
REQ-012 an  out  NUM_DIGITS: active-low one-hot anode enables.
REQ-013 frame_start  out  1: one-cycle pulse at each frame boundary.
REQ-014 pending  out  1: high while a loaded value awaits transfer to display.

Function
REQ-015 Slot counter cnt SHALL count 0..DIV-1 while enable=1; on wrap, digit index idx SHALL advance 0..NUM_DIGITS-1 and wrap to 0.
REQ-016 States: DEAD_T (cnt < DEAD): an = all ones; DRIVE (cnt >= DEAD): an[idx]=0, all other bits 1.
REQ-017 digit SHALL equal nibble idx of the display register, valid the same cycle idx changes; seg is combinational from digit (zero added latency).
REQ-018 load=1 SHALL write value to the pending register and set pending=1 next cycle.
REQ-019 Frame boundary = cycle where cnt wraps and idx wraps to 0; at that edge the pending register SHALL copy to the display register, pending SHALL clear, and frame_start SHALL be 1 for exactly that following cycle.
REQ-020 load coincident with a frame-boundary edge: the previously pending value transfers; the new value remains pending (pending stays 1).
REQ-021 Mid-frame loads SHALL NOT alter the displayed digits of the current frame (no tearing).
REQ-022 lz_blank=1: digit i (i>0) SHALL be blanked (an[i]=1 for the whole slot) when nibbles i..NUM_DIGITS-1 of the display register are all zero; digit 0 is never blanked.
REQ-023 enable=0: next edge forces cnt=0, idx=0, an=all ones; pending transfers to display every cycle (no frame_start pulse); on re-enable scanning restarts with a DEAD_T slot for idx 0.

Reset
REQ-024 rst=1 at any edge, including mid-slot or mid-load, SHALL set cnt=0, idx=0, display register=0, pending register=0, pending=0, frame_start=0, an=all ones, digit=0 (seg = decoder pattern for 0).
REQ-025 load asserted together with rst SHALL be ignored.

Structure
REQ-026 Shared package seg_pkg SHALL hold NUM_DIGITS default, state enum {DEAD_T, DRIVE}, and index/counter width constants via $clog2.
REQ-027 The existing decoder module (in[3:0] -> out[6:0]) SHALL be the single instantiated sub-module producing seg.
REQ-028 Counters, state and registers SHALL be in one sequential block; anode generation combinational from registered state.

Verification (DIV=8, DEAD=2, NUM_DIGITS=4)
REQ-029 Reset, enable=1, load 0x1234: after first frame_start, per slot an = 1111 x2 then 1110 x6 with digit=4, then 1111 x2, 1101 x6 with digit=3, then 2, then 1; repeats.
REQ-030 Displaying 0x1234, load 0xABCD during idx=1: digits 3,2,1 still shown this frame; pending=1 until frame_start; next frame shows D,C,B,A.
REQ-031 lz_blank=1, value 0x0050: an[3], an[2] stay 1 all frame, digit1=5 lit, digit0=0 lit; value 0x0000: only an[0] ever low.
REQ-032 load 0x5555 on the frame-boundary edge with 0x1111 pending: frame shows 1111, pending remains 1, following frame shows 5555.
REQ-033 Deassert enable mid-DRIVE at idx=2: next cycle an=1111, cnt=0, idx=0; reassert: 2 dead cycles then an=1110.
REQ-034 Assert rst mid-frame with load=1: next cycle all outputs at REQ-024 values, pending=0.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared defaults, slot state type and width helpers for the scan driver
package seg_pkg;
  localparam int NUM_DIGITS_DEF = 4;
  localparam int DIV_DEF = 50000;
  localparam int DEAD_DEF = 16;
  localparam int IDX_W_DEF = $clog2(NUM_DIGITS_DEF);
  localparam int CNT_W_DEF = $clog2(DIV_DEF);
  typedef enum logic {DEAD_T, DRIVE} slot_state_t;
  function automatic int width_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/seg_scan_driver_decoder.sv
// seg_scan_driver_decoder: hex nibble to active-high {g,f,e,d,c,b,a} segment pattern
module seg_scan_driver_decoder (
  input  logic [3:0] in,
  output logic [6:0] out
);
  always_comb begin
    out = 7'h00;
    case (in)
      4'h0: out = 7'h3f;
      4'h1: out = 7'h06;
      4'h2: out = 7'h5b;
      4'h3: out = 7'h4f;
      4'h4: out = 7'h66;
      4'h5: out = 7'h6d;
      4'h6: out = 7'h7d;
      4'h7: out = 7'h07;
      4'h8: out = 7'h7f;
      4'h9: out = 7'h6f;
      4'ha: out = 7'h77;
      4'hb: out = 7'h7c;
      4'hc: out = 7'h39;
      4'hd: out = 7'h5e;
      4'he: out = 7'h79;
      default: out = 7'h71;
    endcase
  end
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed hex display scanner with dead time, frame-synchronous update and leading-zero blanking
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int DIV = DIV_DEF,
  parameter int DEAD = DEAD_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    enable,
  input  logic                    lz_blank,
  output logic [3:0]              digit,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start,
  output logic                    pending
);
  localparam int CW = width_of(DIV);
  localparam int IW = width_of(NUM_DIGITS);
  localparam int VW = 4 * NUM_DIGITS;
  logic [CW-1:0] cnt, cnt_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [VW-1:0] disp, pend_reg;
  logic [NUM_DIGITS-1:0] zero_up;
  logic wrap, frame, xfer, blank;
  slot_state_t state, state_nx;
  always_comb begin
    wrap = cnt == CW'(DIV - 1);
    frame = wrap && idx == IW'(NUM_DIGITS - 1);
    xfer = !enable || frame;
    cnt_nx = (!enable || wrap) ? '0 : cnt + 1'b1;
    idx_nx = xfer ? '0 : wrap ? idx + 1'b1 : idx;
    state_nx = (enable && int'(cnt_nx) >= DEAD) ? DRIVE : DEAD_T;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      state <= DEAD_T;
      disp <= '0;
      pend_reg <= '0;
      pending <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      cnt <= cnt_nx;
      idx <= idx_nx;
      state <= state_nx;
      frame_start <= enable && frame;
      if (xfer) disp <= pend_reg;
      pending <= xfer ? load : (pending | load);
      if (load) pend_reg <= value;
    end
  end
  // zero_up[i]: every nibble from i upward is zero, so digit i is a leading zero
  always_comb begin
    zero_up = '0;
    for (int i = 0; i < NUM_DIGITS; i++) zero_up[i] = (disp >> (4 * i)) == '0;
    blank = lz_blank && idx != '0 && zero_up[idx];
    digit = 4'(disp >> (4 * int'(idx)));
    an = (state == DRIVE && !blank) ? ~(NUM_DIGITS'(1) << idx) : '1;
  end
  seg_scan_driver_decoder u_dec (
    .in (digit),
    .out(seg)
  );
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed and random scan checks against a frame-position reference model
module tb_seg_scan_driver;
  localparam int ND = 4;
  localparam int DV = 8;
  localparam int DD = 2;
  localparam int FR = ND * DV;
  logic clk = 0;
  logic rst, load, enable, lz_blank, frame_start, pending;
  logic [15:0] value;
  logic [3:0] digit, an;
  logic [6:0] seg;
  int checks = 0;
  int errors = 0;
  int pos = 0;
  logic [15:0] mdisp = 0, mpv = 0;
  logic mpend = 0, mfs = 0;
  logic [6:0] segtab [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                              7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71};
  seg_scan_driver #(.NUM_DIGITS(ND), .DIV(DV), .DEAD(DD)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .enable(enable), .lz_blank(lz_blank),
    .digit(digit), .seg(seg), .an(an), .frame_start(frame_start), .pending(pending)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick(input logic r, input logic ld, input logic en, input logic lz, input logic [15:0] v);
    int slot, off;
    logic [15:0] nib;
    logic [3:0] exp_an;
    rst = r; load = ld; enable = en; lz_blank = lz; value = v;
    @(posedge clk);
    if (r) begin
      pos = 0; mdisp = 0; mpv = 0; mpend = 0; mfs = 0;
    end else if (!en) begin
      pos = 0; mfs = 0; mdisp = mpv; mpend = ld;
      if (ld) mpv = v;
    end else begin
      mfs = (pos == FR - 1);
      if (mfs) begin mdisp = mpv; mpend = 0; end
      pos = (pos + 1) % FR;
      if (ld) begin mpv = v; mpend = 1; end
    end
    #1;
    slot = pos / DV;
    off = pos % DV;
    nib = mdisp >> (4 * slot);
    exp_an = (off < DD || (lz && slot > 0 && nib == 0)) ? 4'hf : 4'hf ^ (4'b0001 << slot);
    chk("an", {12'b0, an}, {12'b0, exp_an});
    chk("digit", {12'b0, digit}, {12'b0, nib[3:0]});
    chk("seg", {9'b0, seg}, {9'b0, segtab[nib[3:0]]});
    chk("frame_start", {15'b0, frame_start}, {15'b0, mfs});
    chk("pending", {15'b0, pending}, {15'b0, mpend});
  endtask
  task automatic run(input int n, input logic lz);
    for (int i = 0; i < n; i++) tick(0, 0, 1, lz, 16'h0);
  endtask
  initial begin
    repeat (3) tick(1, 0, 0, 0, 16'h0);
    chk("rst_an", {12'b0, an}, 16'h000f);
    chk("rst_seg", {9'b0, seg}, 16'h003f);
    tick(0, 1, 1, 0, 16'h1234);
    run(3 * FR, 0);
    while (pos / DV != 1) tick(0, 0, 1, 0, 16'h0);
    tick(0, 1, 1, 0, 16'habcd);
    chk("mid_load_digit", {12'b0, digit}, 16'h0003);
    run(2 * FR, 0);
    tick(0, 1, 1, 1, 16'h0050);
    run(2 * FR, 1);
    tick(0, 1, 1, 1, 16'h0000);
    run(2 * FR, 1);
    while (pos / DV != 2) tick(0, 0, 1, 0, 16'h0);
    tick(0, 1, 1, 0, 16'h1111);
    while (pos != FR - 1) tick(0, 0, 1, 0, 16'h0);
    tick(0, 1, 1, 0, 16'h5555);
    chk("boundary_pending", {15'b0, pending}, 16'h0001);
    chk("boundary_digit", {12'b0, digit}, 16'h0001);
    run(2 * FR, 0);
    while (!(pos / DV == 2 && pos % DV >= DD)) tick(0, 0, 1, 0, 16'h0);
    tick(0, 0, 0, 0, 16'h0);
    chk("disable_an", {12'b0, an}, 16'h000f);
    repeat (3) tick(0, 0, 0, 0, 16'h0);
    run(2 * FR, 0);
    while (pos != 13) tick(0, 0, 1, 0, 16'h0);
    tick(1, 1, 1, 0, 16'h9999);
    chk("rst_load_pending", {15'b0, pending}, 16'h0000);
    chk("rst_load_digit", {12'b0, digit}, 16'h0000);
    run(FR, 0);
    for (int i = 0; i < 800; i++)
      tick($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 31) != 0,
           (i / 64) % 2 == 1, 16'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
